// File: rtl/dpram_ext.sv
// True dual-port byte-enable RAM with selectable read latency, read-during-write mode and a clear engine.
// Optional collision counter output coll_cnt is enabled by defining DPRAM_EXT_COLL_CNT_EN.
module dpram_ext #(
  parameter int              DATA       = 16,
  parameter int              ADDR       = 10,
  parameter int              RD_LAT     = 1,
  parameter int              RDW_MODE   = 0,
  parameter int              CLR_ON_RST = 1,
  parameter logic [DATA-1:0] INIT_VAL   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  input  logic              a_ce,
  input  logic              a_wr,
  input  logic [DATA/8-1:0] a_be,
  input  logic [ADDR-1:0]   a_addr,
  input  logic [DATA-1:0]   a_din,
  output logic [DATA-1:0]   a_dout,
  output logic              a_valid,
  input  logic              b_ce,
  input  logic              b_wr,
  input  logic [DATA/8-1:0] b_be,
  input  logic [ADDR-1:0]   b_addr,
  input  logic [DATA-1:0]   b_din,
  output logic [DATA-1:0]   b_dout,
  output logic              b_valid,
  output logic              collision
`ifdef DPRAM_EXT_COLL_CNT_EN
  ,
  output logic [15:0]       coll_cnt
`endif
);

  localparam int              NB       = DATA / 8;
  localparam int              DEPTH    = 2 ** ADDR;
  localparam logic [ADDR-1:0] PTR_LAST = '1;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t          state_q, state_d;
  logic [ADDR-1:0] ptr_q, ptr_d;
  logic            clr_accept;

  logic [DATA-1:0] mem [DEPTH];

  logic            a_we, b_we, a_rd, b_rd;
  logic [DATA-1:0] a_old, b_old, a_rdata, b_rdata;
  logic            coll_d, collision_q;
  logic [DATA-1:0] a_dout_q, b_dout_q;
  logic            a_valid_q, b_valid_q;

  // A reset lands in CLEAR when the array must be wiped automatically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      S_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == S_CLEAR);
    clr_done   = (state_q == S_CLEAR) && (ptr_q == PTR_LAST);
    clr_accept = (state_q == S_IDLE) && clr_req;
  end

  assign a_we = a_wr && !busy;
  assign b_we = b_wr && !busy;
  assign a_rd = a_ce && !busy;
  assign b_rd = b_ce && !busy;

  // Port A is applied last so it owns any byte both ports enable.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ptr_q] <= INIT_VAL;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (b_we && b_be[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
        if (a_we && a_be[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
      end
    end
  end

  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  // The other port's write is never forwarded, so cross-port reads always see the old word.
  always_comb begin
    a_rdata = a_old;
    b_rdata = b_old;
    if (RDW_MODE == 1) begin
      for (int i = 0; i < NB; i++) begin
        if (a_we && a_be[i]) a_rdata[8*i +: 8] = a_din[8*i +: 8];
        if (b_we && b_be[i]) b_rdata[8*i +: 8] = b_din[8*i +: 8];
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic            a_s1v_q, b_s1v_q;
      logic [DATA-1:0] a_s1d_q, b_s1d_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_s1v_q   <= 1'b0;
          b_s1v_q   <= 1'b0;
          a_s1d_q   <= '0;
          b_s1d_q   <= '0;
          a_valid_q <= 1'b0;
          b_valid_q <= 1'b0;
          a_dout_q  <= '0;
          b_dout_q  <= '0;
        end else begin
          a_s1v_q   <= a_rd;
          b_s1v_q   <= b_rd;
          if (a_rd) a_s1d_q <= a_rdata;
          if (b_rd) b_s1d_q <= b_rdata;
          a_valid_q <= a_s1v_q;
          b_valid_q <= b_s1v_q;
          if (a_s1v_q) a_dout_q <= a_s1d_q;
          if (b_s1v_q) b_dout_q <= b_s1d_q;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_valid_q <= 1'b0;
          b_valid_q <= 1'b0;
          a_dout_q  <= '0;
          b_dout_q  <= '0;
        end else begin
          a_valid_q <= a_rd;
          b_valid_q <= b_rd;
          if (a_rd) a_dout_q <= a_rdata;
          if (b_rd) b_dout_q <= b_rdata;
        end
      end
    end
  endgenerate

  assign coll_d = a_we && b_we && (a_addr == b_addr) && ((a_be & b_be) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision_q <= 1'b0;
    else        collision_q <= coll_d;
  end

`ifdef DPRAM_EXT_COLL_CNT_EN
  logic [15:0] coll_cnt_q;

  // Counts on the same edge that raises the collision pulse; a new clear sweep zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               coll_cnt_q <= '0;
    else if (clr_accept)                      coll_cnt_q <= '0;
    else if (coll_d && coll_cnt_q != 16'hFFFF) coll_cnt_q <= coll_cnt_q + 16'd1;
  end

  assign coll_cnt = coll_cnt_q;
`endif

  assign a_dout    = a_dout_q;
  assign b_dout    = b_dout_q;
  assign a_valid   = a_valid_q;
  assign b_valid   = b_valid_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_dpram_ext.sv
// Directed bench for dpram_ext: three instances share stimulus and differ in RD_LAT / RDW_MODE.
// Instance 0: RD_LAT=1 RDW_MODE=0, instance 1: RD_LAT=1 RDW_MODE=1, instance 2: RD_LAT=2 RDW_MODE=0.
module tb_dpram_ext;

  logic        clk;
  logic        rst_n;
  logic        clr_req;
  logic        a_ce, a_wr, b_ce, b_wr;
  logic [1:0]  a_be, b_be;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_din, b_din;

  logic [2:0]  busy, clr_done, a_valid, b_valid, collision;
  logic [15:0] a_dout [3];
  logic [15:0] b_dout [3];
`ifdef DPRAM_EXT_COLL_CNT_EN
  logic [15:0] coll_cnt [3];
`endif

  int nCompared;
  int nMismatched;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dpram_ext #(
      .DATA      (16),
      .ADDR      (4),
      .RD_LAT    ((g == 2) ? 2 : 1),
      .RDW_MODE  ((g == 1) ? 1 : 0),
      .CLR_ON_RST(1),
      .INIT_VAL  (16'hA5A5)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .busy     (busy[g]),
      .clr_done (clr_done[g]),
      .a_ce     (a_ce),
      .a_wr     (a_wr),
      .a_be     (a_be),
      .a_addr   (a_addr),
      .a_din    (a_din),
      .a_dout   (a_dout[g]),
      .a_valid  (a_valid[g]),
      .b_ce     (b_ce),
      .b_wr     (b_wr),
      .b_be     (b_be),
      .b_addr   (b_addr),
      .b_din    (b_din),
      .b_dout   (b_dout[g]),
      .b_valid  (b_valid[g]),
      .collision(collision[g])
`ifdef DPRAM_EXT_COLL_CNT_EN
      ,
      .coll_cnt (coll_cnt[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    clr_req = 1'b0;
    a_ce = 1'b0; a_wr = 1'b0; a_be = 2'b00; a_addr = '0; a_din = '0;
    b_ce = 1'b0; b_wr = 1'b0; b_be = 2'b00; b_addr = '0; b_din = '0;
  endtask

  task automatic measureSweep(output int cycles, output int doneAt, output int doneCount);
    cycles = 0; doneAt = -1; doneCount = 0;
    while (busy[0] === 1'b1 && cycles < 100) begin
      if (clr_done[0] === 1'b1) begin
        doneAt = cycles;
        doneCount++;
      end
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cycles, doneAt, doneCount;
    rst_n = 1'b0;
    idleInputs();
    repeat (2) tick();
    nCompared++;
    if (busy !== 3'b111) begin
      nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 111", busy);
    end
    nCompared++;
    if (a_dout[0] !== 16'h0000 || b_dout[0] !== 16'h0000) begin
      nMismatched++; $display("[TB] FAIL reset_dout: got %h/%h expected 0000/0000", a_dout[0], b_dout[0]);
    end
    nCompared++;
    if (a_valid !== 3'b000 || b_valid !== 3'b000 || collision !== 3'b000 || clr_done !== 3'b000) begin
      nMismatched++; $display("[TB] FAIL reset_flags: got av=%b bv=%b coll=%b done=%b expected all 0",
                              a_valid, b_valid, collision, clr_done);
    end
    rst_n = 1'b1;
    measureSweep(cycles, doneAt, doneCount);
    nCompared++;
    if (cycles !== 16) begin
      nMismatched++; $display("[TB] FAIL reset_sweep_len: got %0d expected 16", cycles);
    end
    nCompared++;
    if (doneAt !== 15 || doneCount !== 1) begin
      nMismatched++; $display("[TB] FAIL reset_clr_done: got cycle %0d count %0d expected cycle 15 count 1",
                              doneAt, doneCount);
    end
    for (int i = 0; i < 16; i++) begin
      a_ce = 1'b1; a_addr = 4'(i);
      tick();
      nCompared++;
      if (a_valid[0] !== 1'b1 || a_dout[0] !== 16'hA5A5) begin
        nMismatched++; $display("[TB] FAIL init_read[%0d]: got valid=%b data=%h expected 1/a5a5",
                                i, a_valid[0], a_dout[0]);
      end
    end
    a_ce = 1'b0;
    tick();
    nCompared++;
    if (a_valid[0] !== 1'b0 || a_dout[0] !== 16'hA5A5) begin
      nMismatched++; $display("[TB] FAIL dout_hold: got valid=%b data=%h expected 0/a5a5", a_valid[0], a_dout[0]);
    end
  endtask

  task automatic test_byte_enable();
    a_wr = 1'b1; a_addr = 4'd3; a_din = 16'h1234; a_be = 2'b11;
    tick();
    a_din = 16'hFFEE; a_be = 2'b01;
    tick();
    a_wr = 1'b0; a_be = 2'b00;
    b_ce = 1'b1; b_addr = 4'd3;
    tick();
    nCompared++;
    if (b_valid[0] !== 1'b1 || b_dout[0] !== 16'h12EE) begin
      nMismatched++; $display("[TB] FAIL byte_enable: got valid=%b data=%h expected 1/12ee", b_valid[0], b_dout[0]);
    end
    b_ce = 1'b0;
    a_wr = 1'b1; a_be = 2'b00; a_din = 16'h0000;
    tick();
    a_wr = 1'b0; a_ce = 1'b1;
    tick();
    nCompared++;
    if (a_dout[0] !== 16'h12EE) begin
      nMismatched++; $display("[TB] FAIL be_zero_noop: got %h expected 12ee", a_dout[0]);
    end
    a_ce = 1'b0;
  endtask

  task automatic test_rdw();
    a_wr = 1'b1; a_addr = 4'd5; a_din = 16'h0001; a_be = 2'b11;
    tick();
    a_ce = 1'b1; a_din = 16'h0002;
    tick();
    nCompared++;
    if (a_dout[0] !== 16'h0001) begin
      nMismatched++; $display("[TB] FAIL rdw_old: got %h expected 0001", a_dout[0]);
    end
    nCompared++;
    if (a_dout[1] !== 16'h0002) begin
      nMismatched++; $display("[TB] FAIL rdw_new: got %h expected 0002", a_dout[1]);
    end
    a_wr = 1'b0;
    tick();
    nCompared++;
    if (a_dout[0] !== 16'h0002 || a_dout[1] !== 16'h0002) begin
      nMismatched++; $display("[TB] FAIL rdw_after: got %h/%h expected 0002/0002", a_dout[0], a_dout[1]);
    end
    a_ce = 1'b0;
    a_wr = 1'b1; a_din = 16'h0003;
    b_ce = 1'b1; b_addr = 4'd5;
    tick();
    nCompared++;
    if (b_dout[0] !== 16'h0002 || b_dout[1] !== 16'h0002) begin
      nMismatched++; $display("[TB] FAIL cross_port_old: got %h/%h expected 0002/0002", b_dout[0], b_dout[1]);
    end
    a_wr = 1'b0; b_ce = 1'b0;
  endtask

  task automatic test_collision();
    a_wr = 1'b1; a_addr = 4'd7; a_din = 16'hAAAA; a_be = 2'b10;
    b_wr = 1'b1; b_addr = 4'd7; b_din = 16'h5555; b_be = 2'b11;
    tick();
    nCompared++;
    if (collision[0] !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL collision_pulse: got %b expected 1", collision[0]);
    end
`ifdef DPRAM_EXT_COLL_CNT_EN
    nCompared++;
    if (coll_cnt[0] !== 16'd1) begin
      nMismatched++; $display("[TB] FAIL coll_cnt_one: got %0d expected 1", coll_cnt[0]);
    end
`endif
    a_wr = 1'b0; b_wr = 1'b0;
    a_ce = 1'b1;
    tick();
    nCompared++;
    if (collision[0] !== 1'b0 || a_dout[0] !== 16'hAA55) begin
      nMismatched++; $display("[TB] FAIL collision_merge: got coll=%b data=%h expected 0/aa55",
                              collision[0], a_dout[0]);
    end
    a_ce = 1'b0;
    a_wr = 1'b1; a_addr = 4'd8; a_din = 16'h1100; a_be = 2'b10;
    b_wr = 1'b1; b_addr = 4'd8; b_din = 16'h0022; b_be = 2'b01;
    tick();
    nCompared++;
    if (collision[0] !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL no_overlap_collision: got %b expected 0", collision[0]);
    end
    a_wr = 1'b0; b_wr = 1'b0;
    a_ce = 1'b1;
    tick();
    nCompared++;
    if (a_dout[0] !== 16'h1122) begin
      nMismatched++; $display("[TB] FAIL no_overlap_merge: got %h expected 1122", a_dout[0]);
    end
    a_ce = 1'b0;
  endtask

  task automatic test_read_latency();
    logic [15:0] vals [3];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    a_wr = 1'b1; a_be = 2'b11;
    for (int i = 0; i < 3; i++) begin
      a_addr = 4'(i); a_din = vals[i];
      tick();
    end
    a_wr = 1'b0; a_be = 2'b00;
    a_ce = 1'b1; a_addr = 4'd0;
    tick();
    nCompared++;
    if (a_valid[2] !== 1'b0 || a_valid[0] !== 1'b1 || a_dout[0] !== 16'h1111) begin
      nMismatched++; $display("[TB] FAIL lat_cycle1: got v2=%b v0=%b d0=%h expected 0/1/1111",
                              a_valid[2], a_valid[0], a_dout[0]);
    end
    for (int i = 1; i <= 3; i++) begin
      if (i < 3) a_addr = 4'(i);
      else       a_ce = 1'b0;
      tick();
      nCompared++;
      if (a_valid[2] !== 1'b1 || a_dout[2] !== vals[i-1]) begin
        nMismatched++; $display("[TB] FAIL lat2_cycle%0d: got valid=%b data=%h expected 1/%h",
                                i + 1, a_valid[2], a_dout[2], vals[i-1]);
      end
    end
    tick();
    nCompared++;
    if (a_valid[2] !== 1'b0 || a_dout[2] !== 16'h3333) begin
      nMismatched++; $display("[TB] FAIL lat2_hold: got valid=%b data=%h expected 0/3333", a_valid[2], a_dout[2]);
    end
  endtask

  task automatic test_clear_engine();
    int cycles, doneAt, doneCount;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    nCompared++;
    if (busy[0] !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL clr_req_busy: got %b expected 1", busy[0]);
    end
`ifdef DPRAM_EXT_COLL_CNT_EN
    nCompared++;
    if (coll_cnt[0] !== 16'd0) begin
      nMismatched++; $display("[TB] FAIL coll_cnt_clear: got %0d expected 0", coll_cnt[0]);
    end
`endif
    cycles = 0;
    while (busy[0] === 1'b1 && cycles < 100) begin
      if (cycles == 3) begin
        a_wr = 1'b1; a_be = 2'b11; a_addr = 4'd0; a_din = 16'hDEAD; a_ce = 1'b1;
      end
      if (cycles == 4) begin
        nCompared++;
        if (a_valid[0] !== 1'b0 || a_dout[0] !== 16'h3333) begin
          nMismatched++; $display("[TB] FAIL busy_read_blocked: got valid=%b data=%h expected 0/3333",
                                  a_valid[0], a_dout[0]);
        end
        a_wr = 1'b0; a_be = 2'b00; a_ce = 1'b0;
      end
      tick();
      cycles++;
    end
    nCompared++;
    if (cycles !== 16) begin
      nMismatched++; $display("[TB] FAIL clr_sweep_len: got %0d expected 16", cycles);
    end
    a_ce = 1'b1; a_addr = 4'd0;
    tick();
    nCompared++;
    if (a_dout[0] !== 16'hA5A5) begin
      nMismatched++; $display("[TB] FAIL busy_write_dropped: got %h expected a5a5", a_dout[0]);
    end
    a_addr = 4'd8;
    tick();
    nCompared++;
    if (a_dout[0] !== 16'hA5A5) begin
      nMismatched++; $display("[TB] FAIL clr_overwrite: got %h expected a5a5", a_dout[0]);
    end
    a_ce = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    nCompared++;
    if (busy[0] !== 1'b1 || clr_done[0] !== 1'b0 || a_dout[0] !== 16'h0000 || a_valid[0] !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL abort_reset: got busy=%b done=%b data=%h valid=%b expected 1/0/0000/0",
                              busy[0], clr_done[0], a_dout[0], a_valid[0]);
    end
    tick();
    rst_n = 1'b1;
    measureSweep(cycles, doneAt, doneCount);
    nCompared++;
    if (cycles !== 16 || doneAt !== 15 || doneCount !== 1) begin
      nMismatched++; $display("[TB] FAIL restart_sweep: got len=%0d done@%0d x%0d expected 16/15/1",
                              cycles, doneAt, doneCount);
    end
    a_ce = 1'b1; a_addr = 4'd3;
    tick();
    nCompared++;
    if (a_dout[0] !== 16'hA5A5) begin
      nMismatched++; $display("[TB] FAIL restart_content: got %h expected a5a5", a_dout[0]);
    end
    a_ce = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nCompared = 0;
    nMismatched = 0;
    test_reset();
    test_byte_enable();
    test_rdw();
    test_collision();
    test_read_latency();
    test_clear_engine();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
